alien_spawner: RTL and testbench

Game-flow controller sitting directly upstream of the alien trajectory stage. Picks a pseudo-random entry angle, issues a one-cycle `spawn` pulse with a stable `angle_state`, then monitors the trajectory stage's `ready`/`collision` flags and the shooter's kill pulse. From these it decides the next spawn and maintains lives, score and game-over.

---
 rtl/alien_spawner.sv | 128 ++++++++++++
 tb/tb_alien_spawner.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_spawner.sv
// Game-flow controller: picks entry angles, pulses spawn, tracks lives/score/game-over.
// Optional build macro: ALIEN_SPAWNER_NO_REPEAT_EN (consecutive spawns never share an angle).
module alien_spawner #(
   parameter logic [7:0] SPAWN_DELAY = 8'd30,
   parameter logic [1:0] LIVES       = 2'd3,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       start,
   input  logic       traj_ready,
   input  logic       traj_collision,
   input  logic       alien_killed,
   output logic       spawn,
   output logic [3:0] angle_state,
   output logic       alien_active,
   output logic [1:0] lives,
   output logic [7:0] score,
   output logic       game_over
);

   localparam int unsigned LFSR_W  = 8;
   localparam int unsigned ANGLE_W = 4;
   localparam logic [LFSR_W-1:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_SPAWN,
      S_LAUNCH,
      S_FLY,
      S_OVER
   } state_t;

   state_t              state;
   logic [7:0]          cnt;
   logic [LFSR_W-1:0]   lfsr;
   logic                lfsr_fb_c;
   logic [ANGLE_W-1:0]  next_angle_c;

   assign lfsr_fb_c = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   // Angle latched when WAIT hands over to SPAWN.
   always_comb begin
      next_angle_c = lfsr[ANGLE_W-1:0];
`ifdef ALIEN_SPAWNER_NO_REPEAT_EN
      if (lfsr[ANGLE_W-1:0] == angle_state) begin
         next_angle_c = lfsr[ANGLE_W-1:0] + ANGLE_W'(1);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cnt          <= 8'd0;
         lfsr         <= SEED;
         spawn        <= 1'b0;
         angle_state  <= '0;
         alien_active <= 1'b0;
         lives        <= 2'd0;
         score        <= 8'd0;
         game_over    <= 1'b0;
      end else begin
         lfsr  <= {lfsr[LFSR_W-2:0], lfsr_fb_c};
         spawn <= 1'b0;
         case (state)
            S_IDLE, S_OVER: begin
               if (start) begin
                  lives     <= LIVES;
                  score     <= 8'd0;
                  cnt       <= SPAWN_DELAY;
                  game_over <= 1'b0;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == 8'd0) begin
                  angle_state <= next_angle_c;
                  spawn       <= 1'b1;
                  state       <= S_SPAWN;
               end else if (tick) begin
                  cnt <= cnt - 8'd1;
               end
            end
            S_SPAWN: begin
               state <= S_LAUNCH;
            end
            S_LAUNCH: begin
               if (traj_ready) begin
                  alien_active <= 1'b1;
                  state        <= S_FLY;
               end
            end
            // Collision outranks a kill landing in the same cycle.
            S_FLY: begin
               if (traj_collision) begin
                  alien_active <= 1'b0;
                  lives        <= lives - 2'd1;
                  cnt          <= SPAWN_DELAY;
                  if (lives == 2'd1) begin
                     game_over <= 1'b1;
                     state     <= S_OVER;
                  end else begin
                     state <= S_WAIT;
                  end
               end else if (alien_killed) begin
                  alien_active <= 1'b0;
                  if (score != 8'hFF) begin
                     score <= score + 8'd1;
                  end
                  cnt   <= SPAWN_DELAY;
                  state <= S_WAIT;
               end else if (!traj_ready) begin
                  alien_active <= 1'b0;
                  cnt          <= SPAWN_DELAY;
                  state        <= S_WAIT;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alien_spawner.sv
// Self-checking bench for alien_spawner: directed vector table, mid-flight reset,
// score saturation run and randomized traffic against a behavioural game model.
module tb_alien_spawner;

   localparam int          D       = 3;
   localparam int          NLIVES  = 3;
   localparam logic [7:0]  SEED    = 8'hA5;
   localparam int unsigned OW      = 17;

   localparam int PH_IDLE = 0, PH_WAIT = 1, PH_SPAWN = 2, PH_LAUNCH = 3, PH_FLY = 4, PH_OVER = 5;

   typedef logic [OW-1:0] ovec_t;

   typedef struct {
      logic [3:0] in;       // {start, traj_ready, traj_collision, alien_killed}
      logic       e_spawn;
      logic       e_active;
      logic [1:0] e_lives;
      logic [7:0] e_score;
      logic       e_over;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n, tick, start, traj_ready, traj_collision, alien_killed;
   logic       spawn, alien_active, game_over;
   logic [3:0] angle_state;
   logic [1:0] lives;
   logic [7:0] score;

   int checks = 0;
   int errors = 0;

   // Behavioural game model
   int         ph, left, m_lives, m_score;
   logic [3:0] m_angle;
   logic [7:0] m_lfsr;

   alien_spawner #(
      .SPAWN_DELAY (8'(D)),
      .LIVES       (2'(NLIVES)),
      .LFSR_SEED   (SEED)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .tick           (tick),
      .start          (start),
      .traj_ready     (traj_ready),
      .traj_collision (traj_collision),
      .alien_killed   (alien_killed),
      .spawn          (spawn),
      .angle_state    (angle_state),
      .alien_active   (alien_active),
      .lives          (lives),
      .score          (score),
      .game_over      (game_over)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic logic [3:0] pick_angle(input logic [3:0] cand, input logic [3:0] prev);
`ifdef ALIEN_SPAWNER_NO_REPEAT_EN
      if (cand == prev) return cand + 4'd1;
`endif
      return cand;
   endfunction

   function automatic ovec_t dut_vec();
      return {spawn, angle_state, alien_active, lives, score, game_over};
   endfunction

   function automatic ovec_t model_vec();
      return {ph == PH_SPAWN, m_angle, ph == PH_FLY, 2'(m_lives), 8'(m_score), ph == PH_OVER};
   endfunction

   task automatic check(input string name, input ovec_t act, input ovec_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Advance the game model by one clock using the inputs currently driven.
   task automatic model_edge();
      logic [7:0] cur;
      if (!rst_n) begin
         ph = PH_IDLE; left = 0; m_lives = 0; m_score = 0; m_angle = 4'd0; m_lfsr = SEED;
         return;
      end
      cur    = m_lfsr;
      m_lfsr = lfsr_next(cur);
      case (ph)
         PH_IDLE, PH_OVER:
            if (start) begin
               m_lives = NLIVES; m_score = 0; left = D; ph = PH_WAIT;
            end
         PH_WAIT:
            if (left == 0) begin
               m_angle = pick_angle(cur[3:0], m_angle);
               ph = PH_SPAWN;
            end else if (tick) begin
               left--;
            end
         PH_SPAWN: ph = PH_LAUNCH;
         PH_LAUNCH: if (traj_ready) ph = PH_FLY;
         PH_FLY:
            if (traj_collision) begin
               m_lives--;
               left = D;
               ph = (m_lives == 0) ? PH_OVER : PH_WAIT;
            end else if (alien_killed) begin
               m_score = (m_score >= 255) ? 255 : m_score + 1;
               left = D;
               ph = PH_WAIT;
            end else if (!traj_ready) begin
               left = D;
               ph = PH_WAIT;
            end
         default: ;
      endcase
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] in);
      {start, traj_ready, traj_collision, alien_killed} = in;
   endtask

   function automatic vec_t mk(input logic [3:0] in, input logic es, input logic ea,
                               input logic [1:0] el, input logic [7:0] esc, input logic eo);
      vec_t v;
      v.in = in; v.e_spawn = es; v.e_active = ea; v.e_lives = el; v.e_score = esc; v.e_over = eo;
      return v;
   endfunction

   initial begin
      vec_t       tbl[$];
      logic [3:0] exp_angle;
      bit         found;

      rst_n = 1'b0; tick = 1'b1;
      drive(4'b0000);
      ph = PH_IDLE; left = 0; m_lives = 0; m_score = 0; m_angle = 4'd0; m_lfsr = SEED;

      // Reset held for three edges, then released with no start.
      repeat (3) step();
      rst_n = 1'b1;
      check("reset_state", dut_vec(), '0);
      for (int i = 0; i < 8; i++) begin
         step();
         check("idle_zero", dut_vec(), '0);
      end

      // Directed game: D=3, tick high throughout.
      tbl.push_back(mk(4'b1000, 1'b0, 1'b0, 2'd3, 8'd0, 1'b0));  // start -> WAIT
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd3, 8'd0, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd3, 8'd0, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd3, 8'd0, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd3, 8'd0, 1'b0));  // spawn at cycle D+2
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd3, 8'd0, 1'b0));  // LAUNCH
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd3, 8'd0, 1'b0));
      tbl.push_back(mk(4'b0100, 1'b0, 1'b1, 2'd3, 8'd0, 1'b0));  // FLY
      tbl.push_back(mk(4'b0101, 1'b0, 1'b0, 2'd3, 8'd1, 1'b0));  // kill
      tbl.push_back(mk(4'b1000, 1'b0, 1'b0, 2'd3, 8'd1, 1'b0));  // start in WAIT ignored
      tbl.push_back(mk(4'b0001, 1'b0, 1'b0, 2'd3, 8'd1, 1'b0));  // kill in WAIT ignored
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd3, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd3, 8'd1, 1'b0));  // D+2 after kill
      tbl.push_back(mk(4'b0011, 1'b0, 1'b0, 2'd3, 8'd1, 1'b0));  // events in SPAWN ignored
      tbl.push_back(mk(4'b0111, 1'b0, 1'b1, 2'd3, 8'd1, 1'b0));  // events in LAUNCH ignored
      tbl.push_back(mk(4'b0111, 1'b0, 1'b0, 2'd2, 8'd1, 1'b0));  // collision beats kill
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd2, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd2, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd2, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd2, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd2, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0100, 1'b0, 1'b1, 2'd2, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0100, 1'b0, 1'b1, 2'd2, 8'd1, 1'b0));  // stays in FLY
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd2, 8'd1, 1'b0));  // left screen
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd2, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd2, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd2, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd2, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd2, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0100, 1'b0, 1'b1, 2'd2, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0110, 1'b0, 1'b0, 2'd1, 8'd1, 1'b0));  // second collision
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd1, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd1, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd1, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd1, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd1, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0100, 1'b0, 1'b1, 2'd1, 8'd1, 1'b0));
      tbl.push_back(mk(4'b0110, 1'b0, 1'b0, 2'd0, 8'd1, 1'b1));  // third collision -> OVER
      tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd0, 8'd1, 1'b1));
      tbl.push_back(mk(4'b0101, 1'b0, 1'b0, 2'd0, 8'd1, 1'b1));  // no further spawn
      tbl.push_back(mk(4'b1000, 1'b0, 1'b0, 2'd3, 8'd0, 1'b0));  // restart

      exp_angle = 4'd0;
      foreach (tbl[i]) begin
         drive(tbl[i].in);
         if (tbl[i].e_spawn) exp_angle = pick_angle(m_lfsr[3:0], exp_angle);
         step();
         check($sformatf("vec%0d_flags", i),
               {tbl[i].e_spawn, 4'd0, tbl[i].e_active, tbl[i].e_lives, tbl[i].e_score, tbl[i].e_over},
               {spawn, 4'd0, alien_active, lives, score, game_over});
         check($sformatf("vec%0d_angle", i), 17'(angle_state), 17'(exp_angle));
      end
      drive(4'b0000);

      // Reset while an alien is flying.
      found = 1'b0;
      traj_ready = 1'b1;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         check("fly_seek", dut_vec(), model_vec());
         if (alien_active) found = 1'b1;
      end
      if (!found) begin
         checks++; errors++;
         $display("FAIL fly_seek_timeout actual=not_in_fly required=in_fly");
      end
      rst_n = 1'b0;
      step();
      check("reset_mid_fly", dut_vec(), '0);
      rst_n = 1'b1;
      drive(4'b0000);
      for (int i = 0; i < 5; i++) begin
         step();
         check("post_reset_idle", dut_vec(), model_vec());
      end

      // Back-to-back kills until the score pins at 255.
      drive(4'b1000);
      step();
      check("sat_start", dut_vec(), model_vec());
      drive(4'b0101);
      for (int i = 0; i < 2200; i++) begin
         step();
         check("sat_run", dut_vec(), model_vec());
      end
      check("score_saturated", 17'(score), 17'd255);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst_n          = ($urandom_range(199) != 0);
         tick           = ($urandom_range(3) != 0);
         start          = ($urandom_range(15) == 0);
         traj_ready     = ($urandom_range(3) != 0);
         traj_collision = ($urandom_range(9) == 0);
         alien_killed   = ($urandom_range(5) == 0);
         step();
         check("random", dut_vec(), model_vec());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
